midori64_byte_frontend: RTL

- Byte-serial load/unload stage around the registered Midori64 cipher wrapper (Midori_clk-style core: registers inputs, combinational 16 rounds, registers output).
- Assembles a command byte, an optional 128-bit key and a 64-bit block from an 8-bit valid/ready stream, then drives the core's enc/K/P.
- After the core's fixed latency it captures C and streams the 8 result bytes out over a second valid/ready channel.
- Sits between the byte-wide host interface and the cipher core.

---
 rtl/midori64_byte_frontend_if.sv | 21 ++
 rtl/midori64_byte_frontend.sv | 124 ++++++++++++
 2 files changed

// File: rtl/midori64_byte_frontend_if.sv
// Byte-stream channels between the host and the Midori64 byte frontend.
// The inbound channel carries command, key and block bytes; the outbound channel carries results.
interface midori64_byte_frontend_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/midori64_byte_frontend.sv
// Byte-serial load/unload stage for a registered Midori64 core.
// It assembles the command, optional key and block, waits out the core latency and streams C out.
module midori64_byte_frontend #(
  parameter int unsigned LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  midori64_byte_frontend_if.slave  host,
  output logic                     busy,
  output logic                     enc_o,
  output logic [127:0]             K_o,
  output logic [63:0]              P_o,
  input  logic [63:0]              C_i
);

  typedef enum logic [2:0] {StCmd, StKey, StBlk, StWait, StOut} state_e;

  // The capture edge is the (LAT+1)th edge after the final block byte.
  localparam logic [4:0] WaitLast = 5'(LAT);

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         enc_q, enc_d;
  logic [127:0] key_q, key_d;
  logic [63:0]  blk_q, blk_d;
  logic [63:0]  shift_q, shift_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = host.in_valid && host.in_ready;
  assign out_fire = host.out_valid && host.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCmd;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCmd:   if (in_fire) state_d = host.in_data[1] ? StKey : StBlk;
      StKey:   if (in_fire && cnt_q == 5'd15) state_d = StBlk;
      StBlk:   if (in_fire && cnt_q == 5'd7) state_d = StWait;
      StWait:  if (cnt_q == WaitLast) state_d = StOut;
      StOut:   if (out_fire && cnt_q == 5'd7) state_d = StCmd;
      default: state_d = StCmd;
    endcase
  end

  always_comb begin
    host.in_ready  = rst && (state_q == StCmd || state_q == StKey || state_q == StBlk);
    host.out_valid = (state_q == StOut);
    host.out_last  = (state_q == StOut) && (cnt_q == 5'd7);
    host.out_data  = shift_q[63:56];
    busy           = (state_q != StCmd);
    enc_o          = enc_q;
    K_o            = key_q;
    P_o            = blk_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    key_d   = key_q;
    blk_d   = blk_q;
    shift_d = shift_q;
    unique case (state_q)
      StCmd: begin
        if (in_fire) begin
          enc_d = host.in_data[0];
          cnt_d = 5'd0;
        end
      end
      StKey: begin
        if (in_fire) begin
          key_d = {key_q[119:0], host.in_data};
          cnt_d = (cnt_q == 5'd15) ? 5'd0 : cnt_q + 5'd1;
        end
      end
      StBlk: begin
        if (in_fire) begin
          blk_d = {blk_q[55:0], host.in_data};
          cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
        end
      end
      StWait: begin
        // Earlier core outputs still reflect the partially loaded block.
        if (cnt_q == WaitLast) begin
          shift_d = C_i;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StOut: begin
        if (out_fire) begin
          shift_d = {shift_q[55:0], 8'h00};
          cnt_d   = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 5'd0;
      enc_q   <= 1'b0;
      key_q   <= 128'd0;
      blk_q   <= 64'd0;
      shift_q <= 64'd0;
    end else begin
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      shift_q <= shift_d;
    end
  end

endmodule
